mem_param: RTL and testbench
============================

MEM_PARAM -- requirements
Module: mem_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 16: address port width.
REQ-003 SHALL have parameter DEPTH, default 1024: number of words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: reset.
REQ-006 SHALL have port data_in, input, DATA_W: write data.
REQ-007 SHALL have port address, input, ADDR_W: word address.
REQ-008 SHALL have port write, input, 1: write request.
REQ-009 SHALL have port read, input, 1: read request.
REQ-010 SHALL have port byte_en, input, DATA_W/8: per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-011 SHALL have port data_out, output, DATA_W: registered read data.
REQ-012 SHALL have port valid, output, 1: one-cycle pulse marking new data_out.
REQ-013 SHALL have port ready, output, 1: requests accepted when high.
REQ-014 SHALL have port addr_err, output, 1: one-cycle pulse on out-of-range access.
REQ-015 SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-016 SHALL implement FSM states CLEAR and READY; reset forces CLEAR with clear counter = 0.
REQ-017 In CLEAR, SHALL write all-zero to word[counter] each cycle, counter +1; after word DEPTH-1, next state READY.
REQ-018 ready SHALL be 0 in CLEAR and 1 in READY; ready rises exactly DEPTH cycles after the first clk edge with reset low.
REQ-019 write, read and byte_en SHALL be ignored while ready = 0; no valid or addr_err pulse.
REQ-020 Accepted write (ready=1, write=1, address < DEPTH) SHALL update only the bytes with byte_en[i]=1 at that edge; byte_en = 0 leaves the word unchanged.
REQ-021 Accepted read SHALL present data one cycle later: data_out loaded and valid=1 for exactly one cycle.
REQ-022 data_out SHALL hold its last value until the next accepted read.
REQ-023 Read and write in the same cycle to the same address SHALL return the pre-write word (read-first); the write still takes effect.
REQ-024 Read and write in the same cycle to different addresses SHALL both be performed.
REQ-025 address >= DEPTH: write suppressed; read loads data_out = 0 with valid=1; addr_err=1 for one cycle, one cycle after the request.
REQ-026 Back-to-back reads SHALL produce valid on consecutive cycles; throughput one access per cycle.

Reset
REQ-027 On reset: data_out = 0, valid = 0, addr_err = 0, ready = 0, state CLEAR, counter = 0.
REQ-028 Reset asserted mid-CLEAR or mid-READY SHALL abort activity and restart the clear from word 0; in-flight read results SHALL be discarded (no valid).
REQ-029 Memory contents SHALL be defined only via the clear sequence, not by reset itself.

Structure
REQ-030 Package mem_param_pkg SHALL hold the state typedef (CLEAR, READY) and the default DATA_W, ADDR_W and DEPTH constants.
REQ-031 Storage SHALL be a sub-module mem_param_array (byte-enabled synchronous write, synchronous read-first read port); the FSM, counter, range check and output registers SHALL reside in mem_param.

Verification (DATA_W=32, ADDR_W=16, DEPTH=16)
REQ-032 Reset 2 cycles, release; read addr 5 once ready -> ready rises 16 cycles after release; data_out=0x00000000 with one valid pulse.
REQ-033 Write 0xACEDCAFE to addr 4, byte_en=4'b1111; read addr 4 -> data_out=0xACEDCAFE one cycle after the read.
REQ-034 Write 0xDEADBEEF to addr 4, byte_en=4'b0011; read 4 -> 0xACEDBEEF.
REQ-035 Same cycle write 0x12345678 and read addr 4 -> data_out=0xACEDBEEF; next read 4 -> 0x12345678.
REQ-036 Write then read addr 20 -> addr_err pulse after each; read data_out=0; all 16 words unchanged.
REQ-037 Reset asserted at clear cycle 7 and again after data was written -> ready drops, full 16-cycle clear repeats, read 4 -> 0x00000000, no stray valid.

Source files
------------

// File: rtl/mem_param_pkg.sv
// Shared types and default geometry for the self-clearing byte-enabled memory.
package mem_param_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DEPTH  = 1024;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

endpackage

// File: rtl/mem_param_array.sv
// Word storage with byte-enabled synchronous write and a read-first synchronous read port.
module mem_param_array
  import mem_param_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [IDX_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read and write in one block give read-first behaviour on a shared address.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_param.sv
// Memory front end: zeroes every word after reset, then serves byte-enabled writes
// and registered reads with range checking.
module mem_param
  import mem_param_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [ADDR_W-1:0]   address,
  input  logic                write,
  input  logic                read,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid,
  output logic                ready,
  output logic                addr_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t            state_q;
  logic [IDX_W-1:0]  clearCnt_q;
  logic              valid_q;
  logic              addrErr_q;
  logic              zeroOut_q;

  logic              inRange;
  logic              accRead;
  logic              accWrite;
  logic              memWe;
  logic              memRe;
  logic [BE_W-1:0]   memBe;
  logic [IDX_W-1:0]  memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;

  // Reset gates the array strobes so an aborted cycle never touches storage.
  always_comb begin
    inRange  = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
    accRead  = !reset && (state_q == READY) && read;
    accWrite = !reset && (state_q == READY) && write;
    memWe    = 1'b0;
    memBe    = '0;
    memAddr  = address[IDX_W-1:0];
    memWdata = data_in;
    memRe    = accRead && inRange;
    if (!reset && (state_q == CLEAR)) begin
      memWe    = 1'b1;
      memBe    = '1;
      memAddr  = clearCnt_q;
      memWdata = '0;
    end else if (accWrite && inRange) begin
      memWe = 1'b1;
      memBe = byte_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clearCnt_q <= '0;
      valid_q    <= 1'b0;
      addrErr_q  <= 1'b0;
      zeroOut_q  <= 1'b1;
    end else begin
      valid_q   <= 1'b0;
      addrErr_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          clearCnt_q <= clearCnt_q + 1'b1;
          if (clearCnt_q == LAST_IDX) begin
            clearCnt_q <= '0;
            state_q    <= READY;
          end
        end
        READY: begin
          // Out-of-range reads show zero without disturbing the array's read register.
          if (accRead) begin
            valid_q   <= 1'b1;
            zeroOut_q <= !inRange;
          end
          if ((accRead || accWrite) && !inRange) begin
            addrErr_q <= 1'b1;
          end
        end
      endcase
    end
  end

  mem_param_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (memWe),
    .be_i    (memBe),
    .addr_i  (memAddr),
    .wdata_i (memWdata),
    .re_i    (memRe),
    .rdata_o (memRdata)
  );

  assign data_out = zeroOut_q ? '0 : memRdata;
  assign valid    = valid_q;
  assign addr_err = addrErr_q;
  assign ready    = (state_q == READY);

endmodule

// File: tb/tb_mem_param.sv
// Scoreboard bench for mem_param with a 16-word memory and a reference word model.
module tb_mem_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic [ADDR_W-1:0] address = '0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [BE_W-1:0]   byte_en = '0;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ready;
  logic              addr_err;

  typedef struct {
    string       tag;
    logic        expValid;
    logic        expErr;
    logic [31:0] expData;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] model[DEPTH];
  bit          modelReady = 1'b0;
  int          testsRun = 0;
  int          testsFailed = 0;

  mem_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .address  (address),
    .write    (write),
    .read     (read),
    .byte_en  (byte_en),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every valid or addr_err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid || addr_err) begin
      if (expQ.size() == 0) begin
        checkOutput("strayPulse", {62'd0, valid, addr_err}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".valid"}, valid, e.expValid);
        checkOutput({e.tag, ".err"}, addr_err, e.expErr);
        if (e.expValid) checkOutput({e.tag, ".data"}, data_out, e.expData);
      end
    end
  end

  task automatic applyStimulus(input bit wr, input bit rd, input logic [15:0] addr,
                               input logic [31:0] data, input logic [3:0] be, input string tag);
    bit          inRange;
    logic [31:0] rdExp;
    write   = wr;
    read    = rd;
    address = addr;
    data_in = data;
    byte_en = be;
    if (modelReady) begin
      inRange = (addr < DEPTH);
      rdExp   = 32'h0;
      if (rd && inRange) rdExp = model[addr[3:0]];
      if (rd || (wr && !inRange)) expQ.push_back('{tag, rd, !inRange, rdExp});
      if (wr && inRange) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) model[addr[3:0]][8*i +: 8] = data[8*i +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    write   = 1'b0;
    read    = 1'b0;
    byte_en = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int n);
    reset      = 1'b1;
    modelReady = 1'b0;
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
    checkOutput("rst.ready", ready, 1'b0);
    checkOutput("rst.valid", valid, 1'b0);
    checkOutput("rst.err", addr_err, 1'b0);
    checkOutput("rst.data", data_out, 32'h0);
    reset = 1'b0;
  endtask

  task automatic waitReady(input int elapsed);
    int cnt = elapsed;
    while (!ready && cnt < 64) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("readyLatency", cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    modelReady = 1'b1;
  endtask

  initial begin
    applyReset(2);
    waitReady(0);
    applyStimulus(0, 1, 16'd5, 32'h0, 4'h0, "rd5Cleared");
    idle(1);

    applyStimulus(1, 0, 16'd4, 32'hACEDCAFE, 4'b1111, "wr4Full");
    applyStimulus(0, 1, 16'd4, 32'h0, 4'h0, "rd4Full");
    applyStimulus(1, 0, 16'd4, 32'hDEADBEEF, 4'b0011, "wr4Low");
    applyStimulus(0, 1, 16'd4, 32'h0, 4'h0, "rd4Low");
    applyStimulus(1, 0, 16'd4, 32'hFFFFFFFF, 4'b0000, "wr4NoBe");
    applyStimulus(0, 1, 16'd4, 32'h0, 4'h0, "rd4NoBe");
    applyStimulus(1, 1, 16'd4, 32'h12345678, 4'b1111, "rdFirst");
    applyStimulus(0, 1, 16'd4, 32'h0, 4'h0, "rdAfterWr");
    idle(3);
    checkOutput("holdData", data_out, 32'h12345678);
    checkOutput("holdValid", valid, 1'b0);

    applyStimulus(1, 0, 16'd20, 32'hBAD0BAD0, 4'b1111, "wrOor");
    idle(1);
    applyStimulus(0, 1, 16'd20, 32'h0, 4'h0, "rdOor");
    idle(1);
    checkOutput("oorData", data_out, 32'h0);
    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 1, 16'(a), 32'h0, 4'h0, "dump");
    idle(2);

    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 17)), $urandom, 4'($urandom_range(0, 15)), "rand");
    end
    idle(2);

    applyReset(2);
    for (int c = 0; c < 7; c++) applyStimulus(1, 1, 16'd4, 32'hFFFFFFFF, 4'hF, "clearIgnored");
    applyReset(1);
    waitReady(0);
    applyStimulus(0, 1, 16'd4, 32'h0, 4'h0, "rd4AfterAbort");
    applyStimulus(1, 0, 16'd4, 32'h55AA55AA, 4'hF, "wr4Again");
    read    = 1'b1;
    address = 16'd4;
    applyReset(2);
    for (int c = 0; c < 3; c++) applyStimulus(1, 1, 16'd4, 32'hFFFFFFFF, 4'hF, "clearIgnored2");
    waitReady(3);
    applyStimulus(0, 1, 16'd4, 32'h0, 4'h0, "rd4Recleared");
    applyStimulus(0, 1, 16'd5, 32'h0, 4'h0, "rd5Recleared");
    idle(3);

    checkOutput("drain", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
